// File: rtl/farm_imem_loader.sv
// Framed byte-stream loader for the instruction memory; holds the core in reset until a verified image is in place.
// Optional inter-byte timeout: define FARM_LOADER_TIMEOUT_EN.
module farm_imem_loader #(
    parameter int         ADDR_W      = 8,
    parameter int         BASE_ADDR   = 0,
    parameter logic [7:0] MAGIC       = 8'hA5,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       DEPTH = 32'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [23:0]       word_q, word_d;
    logic [1:0]        bidx_q, bidx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   ww_q, ww_d;
    logic [1:0]        code_q, code_d;
    logic              ready_q, ready_d;
    logic              accept;
    logic [31:0]       n_words;

`ifdef FARM_LOADER_TIMEOUT_EN
    logic [31:0]       to_q, to_d;
`endif

    assign accept  = byte_valid & ready_q;
    assign n_words = {16'h0, byte_data, cnt_q[7:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        word_d  = word_q;
        bidx_d  = bidx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ww_d    = ww_q;
        code_d  = code_q;

        // Address advances in the cycle after the strobe so the strobe sees BASE_ADDR+k.
        if (we_q) addr_d = addr_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (accept && byte_data == MAGIC) begin
                    state_d = S_CNT_LO;
                    csum_d  = '0;
                    bidx_d  = '0;
                    ww_d    = '0;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    cnt_d[7:0] = byte_data;
                    csum_d     = csum_q ^ byte_data;
                    state_d    = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    cnt_d[15:8] = byte_data;
                    csum_d      = csum_q ^ byte_data;
                    if (n_words > DEPTH) begin
                        state_d = S_ERR;
                        code_d  = 2'd2;
                    end else if (n_words == 32'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ byte_data;
                    bidx_d = bidx_q + 1'b1;
                    unique case (bidx_q)
                        2'd0: word_d[7:0]   = byte_data;
                        2'd1: word_d[15:8]  = byte_data;
                        2'd2: word_d[23:16] = byte_data;
                        default: begin
                            we_d    = 1'b1;
                            wdata_d = {byte_data, word_q};
                            ww_d    = ww_q + 1'b1;
                            if (32'(ww_q) + 32'd1 == {16'h0, cnt_q}) state_d = S_CSUM;
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (byte_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        code_d  = 2'd1;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    state_d = S_IDLE;
                    code_d  = '0;
                    addr_d  = BASE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef FARM_LOADER_TIMEOUT_EN
        if (accept || state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR) begin
            to_d = '0;
        end else begin
            to_d = to_q + 32'd1;
            if (to_d == 32'(TIMEOUT_CYC)) begin
                state_d = S_ERR;
                code_d  = 2'd3;
            end
        end
`endif

        ready_d = !(state_d == S_DONE || state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            csum_q  <= '0;
            word_q  <= '0;
            bidx_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE;
            wdata_q <= '0;
            ww_q    <= '0;
            code_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            word_q  <= word_d;
            bidx_q  <= bidx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ww_q    <= ww_d;
            code_q  <= code_d;
            ready_q <= ready_d;
        end
    end

`ifdef FARM_LOADER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_q <= '0;
        else        to_q <= to_d;
    end
`endif

    assign byte_ready    = ready_q;
    assign imem_we       = we_q;
    assign imem_addr     = addr_q;
    assign imem_wdata    = wdata_q;
    assign done          = (state_q == S_DONE);
    assign error         = (state_q == S_ERR);
    assign core_rst_n    = (state_q == S_DONE);
    assign err_code      = code_q;
    assign words_written = ww_q;

endmodule
